// File: rtl/hw_loop_controller.sv
// Hardware loop sequencer: a small stack of {start PC, remaining count} entries
// driven by single-cycle LOOP / ENDLOOP pulses from the instruction decoder.
module hw_loop_controller #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       loop_start,
  input  logic [DATA_W-1:0]          loop_count,
  input  logic [ADDR_W-1:0]          loop_pc,
  input  logic                       loop_end,
  input  logic                       err_clear,
  output logic                       branch_valid,
  output logic [ADDR_W-1:0]          branch_pc,
  output logic                       loop_done,
  output logic [$clog2(DEPTH):0]     depth,
  output logic [DATA_W-1:0]          top_count,
  output logic                       top_last,
  output logic                       ovf_err,
  output logic                       udf_err,
  output logic                       proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] pc_q, pc_d;
  logic [DEPTH-1:0][DATA_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]                depth_q, depth_d;
  logic                         bv_q, bv_d;
  logic [ADDR_W-1:0]            bpc_q, bpc_d;
  logic                         done_q, done_d;
  logic                         ovf_q, ovf_d;
  logic                         udf_q, udf_d;
  logic                         proto_q, proto_d;

  logic [AW-1:0]                top_idx_s;
  logic [AW-1:0]                push_idx_s;
  logic                         empty_s;
  logic                         full_s;
  logic [DATA_W-1:0]            top_cnt_s;

  // When full, depth's low bits wrap to 0, so top_idx still lands on DEPTH-1.
  assign top_idx_s  = depth_q[AW-1:0] - AW'(1);
  assign push_idx_s = depth_q[AW-1:0];
  assign empty_s    = (depth_q == DW'(0));
  assign full_s     = (depth_q == DW'(DEPTH));
  assign top_cnt_s  = empty_s ? DATA_W'(0) : cnt_q[top_idx_s];

  // Next-state: one stack operation per cycle, loop_end has priority over loop_start.
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    depth_d = depth_q;
    bv_d    = 1'b0;
    bpc_d   = bpc_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q   & ~err_clear;
    udf_d   = udf_q   & ~err_clear;
    proto_d = proto_q & ~err_clear;
    if (loop_end) begin
      if (empty_s) begin
        udf_d = 1'b1;
      end else if (top_cnt_s > DATA_W'(1)) begin
        cnt_d[top_idx_s] = top_cnt_s - DATA_W'(1);
        bv_d             = 1'b1;
        bpc_d            = pc_q[top_idx_s];
      end else begin
        depth_d = depth_q - DW'(1);
        done_d  = 1'b1;
      end
      if (loop_start) begin
        proto_d = 1'b1;
      end else begin
        proto_d = proto_d;
      end
    end else if (loop_start) begin
      if (full_s) begin
        ovf_d = 1'b1;
      end else begin
        pc_d[push_idx_s]  = loop_pc;
        cnt_d[push_idx_s] = (loop_count == DATA_W'(0)) ? DATA_W'(1) : loop_count;
        depth_d           = depth_q + DW'(1);
      end
    end else begin
      depth_d = depth_q;
    end
  end

  // State and registered pulse/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      cnt_q   <= '0;
      depth_q <= '0;
      bv_q    <= 1'b0;
      bpc_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
      bv_q    <= bv_d;
      bpc_q   <= bpc_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      proto_q <= proto_d;
    end
  end

  assign branch_valid = bv_q;
  assign branch_pc    = bpc_q;
  assign loop_done    = done_q;
  assign depth        = depth_q;
  assign top_count    = top_cnt_s;
  assign top_last     = !empty_s && (top_cnt_s == DATA_W'(1));
  assign ovf_err      = ovf_q;
  assign udf_err      = udf_q;
  assign proto_err    = proto_q;

endmodule

// File: tb/tb_hw_loop_controller.sv
// Self-checking bench: queue-based loop-stack model checked every cycle,
// directed scenarios with literal expectations, then randomized pulses.
module tb_hw_loop_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        loop_start = 1'b0;
  logic [15:0] loop_count = 16'd0;
  logic [7:0]  loop_pc = 8'd0;
  logic        loop_end = 1'b0;
  logic        err_clear = 1'b0;
  logic        branch_valid;
  logic [7:0]  branch_pc;
  logic        loop_done;
  logic [2:0]  depth;
  logic [15:0] top_count;
  logic        top_last;
  logic        ovf_err, udf_err, proto_err;

  int errors = 0;
  int checks = 0;

  hw_loop_controller #(.DATA_W(16), .ADDR_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .loop_start(loop_start), .loop_count(loop_count),
    .loop_pc(loop_pc), .loop_end(loop_end), .err_clear(err_clear),
    .branch_valid(branch_valid), .branch_pc(branch_pc), .loop_done(loop_done),
    .depth(depth), .top_count(top_count), .top_last(top_last),
    .ovf_err(ovf_err), .udf_err(udf_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a stack of loops as two queues plus expected pulses.
  logic [7:0] m_pc[$];
  int         m_cnt[$];
  bit         m_bv, m_done, m_ovf, m_udf, m_proto;
  logic [7:0] m_bpc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc.delete(); m_cnt.delete();
      m_bv = 0; m_done = 0; m_bpc = 8'd0;
      m_ovf = 0; m_udf = 0; m_proto = 0;
    end else begin
      m_bv = 0; m_done = 0;
      if (err_clear) begin m_ovf = 0; m_udf = 0; m_proto = 0; end
      if (loop_end) begin
        if (m_cnt.size() == 0) m_udf = 1;
        else if (m_cnt[m_cnt.size()-1] > 1) begin
          m_cnt[m_cnt.size()-1] = m_cnt[m_cnt.size()-1] - 1;
          m_bv = 1; m_bpc = m_pc[m_pc.size()-1];
        end else begin
          void'(m_cnt.pop_back()); void'(m_pc.pop_back()); m_done = 1;
        end
        if (loop_start) m_proto = 1;
      end else if (loop_start) begin
        if (m_cnt.size() == 4) m_ovf = 1;
        else begin
          m_pc.push_back(loop_pc);
          m_cnt.push_back(loop_count == 16'd0 ? 1 : int'(loop_count));
        end
      end
    end
  end

  // Compare process: every falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      int exp_top;
      exp_top = (m_cnt.size() == 0) ? 0 : m_cnt[m_cnt.size()-1];
      check("branch_valid", 32'(branch_valid), 32'(m_bv));
      if (m_bv) check("branch_pc", 32'(branch_pc), 32'(m_bpc));
      check("loop_done", 32'(loop_done), 32'(m_done));
      check("depth", 32'(depth), 32'(m_cnt.size()));
      check("top_count", 32'(top_count), 32'(exp_top));
      check("top_last", 32'(top_last), 32'(exp_top == 1));
      check("ovf_err", 32'(ovf_err), 32'(m_ovf));
      check("udf_err", 32'(udf_err), 32'(m_udf));
      check("proto_err", 32'(proto_err), 32'(m_proto));
      check("pulse_excl", 32'(branch_valid & loop_done), 32'd0);
    end
  end

  // Drive one cycle of inputs right after a falling edge, then wait for the next one.
  task automatic cyc(input bit ls, input bit le, input int cnt, input int pc, input bit ec);
    loop_start = ls; loop_end = le; loop_count = 16'(cnt); loop_pc = 8'(pc); err_clear = ec;
    @(negedge clk);
    loop_start = 1'b0; loop_end = 1'b0; err_clear = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_bv"}, 32'(branch_valid), 32'd0);
    check({tag, "_bpc"}, 32'(branch_pc), 32'd0);
    check({tag, "_done"}, 32'(loop_done), 32'd0);
    check({tag, "_depth"}, 32'(depth), 32'd0);
    check({tag, "_top"}, 32'(top_count), 32'd0);
    check({tag, "_last"}, 32'(top_last), 32'd0);
    check({tag, "_errs"}, {29'd0, ovf_err, udf_err, proto_err}, 32'd0);
  endtask

  initial begin
    #12;
    all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Single loop, count 3
    cyc(1, 0, 3, 'h10, 0);
    check("s_top3", 32'(top_count), 32'd3);
    cyc(0, 1, 0, 0, 0);
    check("s_bv1", 32'(branch_valid), 32'd1); check("s_pc1", 32'(branch_pc), 32'h10);
    check("s_top2", 32'(top_count), 32'd2);
    cyc(0, 1, 0, 0, 0);
    check("s_bv2", 32'(branch_valid), 32'd1); check("s_last", 32'(top_last), 32'd1);
    cyc(0, 1, 0, 0, 0);
    check("s_done", 32'(loop_done), 32'd1); check("s_depth0", 32'(depth), 32'd0);
    check("s_nobv", 32'(branch_valid), 32'd0);

    // Counts 0 and 1 exit on the first loop_end
    for (int c = 0; c < 2; c++) begin
      cyc(1, 0, c, 'h40, 0);
      check("c_top1", 32'(top_count), 32'd1);
      cyc(0, 1, 0, 0, 0);
      check("c_done", 32'(loop_done), 32'd1); check("c_nobv", 32'(branch_valid), 32'd0);
    end

    // Nesting
    cyc(1, 0, 2, 'h10, 0);
    cyc(1, 0, 2, 'h20, 0);
    check("n_depth2", 32'(depth), 32'd2);
    cyc(0, 1, 0, 0, 0); check("n_pc20", 32'(branch_pc), 32'h20);
    cyc(0, 1, 0, 0, 0); check("n_done1", 32'(loop_done), 32'd1);
    check("n_outer", 32'(top_count), 32'd2);
    cyc(0, 1, 0, 0, 0); check("n_pc10", 32'(branch_pc), 32'h10);
    cyc(0, 1, 0, 0, 0); check("n_depth0", 32'(depth), 32'd0);

    // Overflow, drain, underflow, clear
    for (int i = 0; i < 5; i++) cyc(1, 0, 2, 'h31 + i, 0);
    check("o_depth4", 32'(depth), 32'd4); check("o_ovf", 32'(ovf_err), 32'd1);
    cyc(0, 1, 0, 0, 0); check("o_toppc", 32'(branch_pc), 32'h34);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0);
    check("o_drained", 32'(depth), 32'd0);
    cyc(0, 1, 0, 0, 0);
    check("u_udf", 32'(udf_err), 32'd1); check("u_nobv", 32'(branch_valid), 32'd0);
    check("u_nodone", 32'(loop_done), 32'd0);
    cyc(0, 0, 0, 0, 1);
    check("clr_ovf", 32'(ovf_err), 32'd0); check("clr_udf", 32'(udf_err), 32'd0);

    // Collision
    cyc(1, 0, 2, 'h55, 0);
    cyc(1, 1, 7, 'h66, 0);
    check("p_bv", 32'(branch_valid), 32'd1); check("p_top", 32'(top_count), 32'd1);
    check("p_depth", 32'(depth), 32'd1); check("p_err", 32'(proto_err), 32'd1);
    cyc(0, 1, 0, 0, 1);
    check("p_setwins", 32'(udf_err), 32'd0);

    // Async reset mid-loop
    for (int i = 0; i < 3; i++) cyc(1, 0, 4, 'h70 + i, 0);
    check("r_depth3", 32'(depth), 32'd3);
    #2 rst_n = 1'b0;
    #1 all_zero("areset");
    @(negedge clk); rst_n = 1'b1;
    cyc(0, 1, 0, 0, 0);
    check("r_udf", 32'(udf_err), 32'd1);
    cyc(0, 0, 0, 0, 1);

    // Randomized pulses
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc(r < 35, (r >= 30 && r < 75), $urandom_range(0, 3), $urandom_range(0, 255),
          $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
